// File: rtl/fp_arbiter.sv
// Round-robin arbiter that shares one fpUnit among NUM_REQ requesters.
// Operands are latched at grant time and held for the whole operation.
module fp_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_clk_en,
   input  logic [NUM_REQ*32-1:0]  req_dataa,
   input  logic [NUM_REQ*32-1:0]  req_datab,
   input  logic [NUM_REQ*3-1:0]   req_operation,
   output logic [NUM_REQ-1:0]     req_done,
   output logic [31:0]            req_result,
   output logic [31:0]            fp_dataa,
   output logic [31:0]            fp_datab,
   output logic [2:0]             fp_operation,
   output logic                   fp_clk_en,
   input  logic                   fp_done,
   input  logic [31:0]            fp_result,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RELEASE
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   winner_idx;
   logic               winner_found;
   logic [IDX_W:0]     rr_sum;
   logic [CNT_W-1:0]   wait_cnt;
   logic               timeout_hit;
   logic [31:0]        sel_dataa;
   logic [31:0]        sel_datab;
   logic [2:0]         sel_op;

   // Scan from the slot after the last owner, wrapping, so the previous owner
   // comes last; it is also never eligible while RELEASE is in progress since
   // arbitration only runs from IDLE.
   always_comb begin
      winner_found = 1'b0;
      winner_idx   = '0;
      rr_sum       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_sum = {1'b0, last_grant} + (IDX_W+1)'(k);
         if (rr_sum >= (IDX_W+1)'(NUM_REQ))
            rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
         if (!winner_found && req_clk_en[rr_sum[IDX_W-1:0]]) begin
            winner_found = 1'b1;
            winner_idx   = rr_sum[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      sel_dataa = '0;
      sel_datab = '0;
      sel_op    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner_idx == IDX_W'(i)) begin
            sel_dataa = req_dataa[i*32 +: 32];
            sel_datab = req_datab[i*32 +: 32];
            sel_op    = req_operation[i*3 +: 3];
         end
      end
   end

   always_comb begin
      state_next  = state;
      timeout_hit = 1'b0;
      req_done    = '0;
      req_result  = '0;
      case (state)
         IDLE: begin
            if (winner_found)
               state_next = BUSY;
         end
         BUSY: begin
            timeout_hit = !fp_done && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
            if (fp_done) begin
               req_done   = grant;
               req_result = fp_result;
               state_next = RELEASE;
            end else if (timeout_hit) begin
               req_done   = grant;
               state_next = RELEASE;
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign fp_clk_en = (state == BUSY);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Reset leaves last_grant pointing at the top slot so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant        <= '0;
         last_grant   <= IDX_W'(NUM_REQ - 1);
         fp_dataa     <= '0;
         fp_datab     <= '0;
         fp_operation <= '0;
         wait_cnt     <= '0;
         timeout_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (winner_found) begin
                  grant        <= NUM_REQ'(1) << winner_idx;
                  last_grant   <= winner_idx;
                  fp_dataa     <= sel_dataa;
                  fp_datab     <= sel_datab;
                  fp_operation <= sel_op;
                  wait_cnt     <= '0;
               end
            end
            BUSY: begin
               wait_cnt <= wait_cnt + CNT_W'(1);
               if (timeout_hit)
                  timeout_err <= 1'b1;
            end
            RELEASE: grant <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_arbiter.sv
// Self-checking bench for fp_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_fp_arbiter;

   localparam int N = 4;
   localparam int T = 64;
   localparam int PH_IDLE = 0;
   localparam int PH_BUSY = 1;
   localparam int PH_REL  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_clk_en;
   logic [N*32-1:0]  req_dataa;
   logic [N*32-1:0]  req_datab;
   logic [N*3-1:0]   req_operation;
   logic [N-1:0]     req_done;
   logic [31:0]      req_result;
   logic [31:0]      fp_dataa;
   logic [31:0]      fp_datab;
   logic [2:0]       fp_operation;
   logic             fp_clk_en;
   logic             fp_done;
   logic [31:0]      fp_result;
   logic [N-1:0]     grant;
   logic             busy;
   logic             timeout_err;

   fp_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .req_clk_en(req_clk_en), .req_dataa(req_dataa), .req_datab(req_datab),
      .req_operation(req_operation), .req_done(req_done), .req_result(req_result),
      .fp_dataa(fp_dataa), .fp_datab(fp_datab), .fp_operation(fp_operation),
      .fp_clk_en(fp_clk_en), .fp_done(fp_done), .fp_result(fp_result),
      .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int          mPhase, mOwner, mLast, mCnt, mLat;
   bit          mTerr, mOpsZero;
   logic [31:0] mA, mB;
   logic [2:0]  mOp;

   bit          autoReq, holdReq, scramble, strayEn, useFixed, forceFpDone;
   int          forceLat;
   logic [31:0] fixedResult;
   bit [N-1:0]  pend, dropped, lastDone;
   logic [N-1:0] capDone, prevGrant;
   logic [31:0] capRes;
   int          doneCnt;
   logic [N-1:0] grantQ[$];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mPhase = PH_IDLE; mOwner = 0; mLast = N - 1; mCnt = 0; mLat = 0;
      mTerr = 1'b0; mA = '0; mB = '0; mOp = '0; mOpsZero = 1'b1;
   endtask

   // Model advance at a clock edge, from the rules of the arbiter's behaviour.
   task automatic updateModel();
      if (rst) begin
         modelReset();
      end else if (mPhase == PH_IDLE) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (mLast + k) % N;
            if (req_clk_en[c]) begin
               mPhase = PH_BUSY; mOwner = c; mLast = c; mCnt = 0;
               mA = req_dataa[c*32 +: 32]; mB = req_datab[c*32 +: 32];
               mOp = req_operation[c*3 +: 3]; mOpsZero = 1'b0;
               if (forceLat >= 0) mLat = forceLat;
               else mLat = ($urandom % 20 == 0) ? 0 : int'($urandom_range(1, 10));
               break;
            end
         end
      end else if (mPhase == PH_BUSY) begin
         if (fp_done) mPhase = PH_REL;
         else if (mCnt == T - 1) begin mPhase = PH_REL; mTerr = 1'b1; end
         else mCnt++;
      end else begin
         mPhase = PH_IDLE;
      end
   endtask

   task automatic applyStimulus();
      if (autoReq) begin
         for (int i = 0; i < N; i++) begin
            if (lastDone[i]) begin pend[i] = 1'b0; dropped[i] = 1'b0; end
            else if (!pend[i] && ($urandom % 3 == 0)) begin
               pend[i] = 1'b1;
               req_dataa[i*32 +: 32] = $urandom;
               req_datab[i*32 +: 32] = $urandom;
               req_operation[i*3 +: 3] = 3'($urandom);
            end
            if (pend[i] && mPhase == PH_BUSY && mOwner == i && ($urandom % 16 == 0))
               dropped[i] = 1'b1;
            req_clk_en[i] = pend[i] && !dropped[i];
         end
      end else if (!holdReq) begin
         req_clk_en = req_clk_en & ~lastDone;
      end
      if (scramble && mPhase == PH_BUSY && ($urandom % 2 == 0)) begin
         req_dataa[mOwner*32 +: 32] = $urandom;
         req_datab[mOwner*32 +: 32] = $urandom;
         req_operation[mOwner*3 +: 3] = 3'($urandom);
      end
      fp_result = useFixed ? fixedResult : $urandom;
      if (mPhase == PH_BUSY)
         fp_done = (mLat > 0) && (mCnt == mLat - 1);
      else
         fp_done = forceFpDone || (strayEn && ($urandom % 4 == 0));
   endtask

   task automatic compareCycle();
      logic [N-1:0] expGrant, expDone;
      logic [31:0]  expRes;
      bit           inBusy, tmo;
      inBusy   = (mPhase == PH_BUSY);
      expGrant = (mPhase == PH_IDLE) ? '0 : (N'(1) << mOwner);
      tmo      = inBusy && !fp_done && (mCnt == T - 1);
      expDone  = (inBusy && (fp_done || tmo)) ? (N'(1) << mOwner) : '0;
      expRes   = (inBusy && fp_done) ? fp_result : 32'h0;
      checkOutput("busy", 32'(busy), 32'(mPhase != PH_IDLE));
      checkOutput("grant", 32'(grant), 32'(expGrant));
      checkOutput("fp_clk_en", 32'(fp_clk_en), 32'(inBusy));
      checkOutput("req_done", 32'(req_done), 32'(expDone));
      checkOutput("req_result", req_result, expRes);
      checkOutput("timeout_err", 32'(timeout_err), 32'(mTerr));
      if (inBusy || mOpsZero) begin
         checkOutput("fp_dataa", fp_dataa, mA);
         checkOutput("fp_datab", fp_datab, mB);
         checkOutput("fp_operation", 32'(fp_operation), 32'(mOp));
      end
      lastDone = expDone;
      if (req_done !== '0) begin capDone = req_done; capRes = req_result; doneCnt++; end
      if (busy && grant !== prevGrant && grant !== '0) grantQ.push_back(grant);
      prevGrant = grant;
   endtask

   task automatic runCycles(input int n);
      repeat (n) begin
         applyStimulus();
         #4;
         compareCycle();
         @(posedge clk);
         updateModel();
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; req_clk_en = '0; req_dataa = '0; req_datab = '0; req_operation = '0;
      fp_done = 1'b0; fp_result = '0;
      autoReq = 0; holdReq = 0; scramble = 0; strayEn = 0; useFixed = 0; forceFpDone = 0;
      forceLat = -1; fixedResult = '0; pend = '0; dropped = '0; lastDone = '0;
      capDone = '0; capRes = '0; doneCnt = 0; prevGrant = '0;
      modelReset();
      @(posedge clk);
      #1;
      runCycles(2);

      // Single request from requester 1, result after 5 busy cycles
      rst = 1'b0;
      req_dataa[32 +: 32] = 32'h40000000;
      req_datab[32 +: 32] = 32'h40400000;
      req_operation[3 +: 3] = 3'd3;
      req_clk_en = 4'b0010;
      forceLat = 5; useFixed = 1; fixedResult = 32'h40C00000;
      runCycles(10);
      checkOutput("single_done", 32'(capDone), 32'h2);
      checkOutput("single_result", capRes, 32'h40C00000);
      checkOutput("single_count", doneCnt, 1);
      useFixed = 0;

      // All four requesting continuously after reset
      rst = 1'b1; runCycles(1); rst = 1'b0;
      holdReq = 1; forceLat = -1; req_clk_en = 4'b1111;
      grantQ.delete();
      for (int c = 0; c < 400 && grantQ.size() < 5; c++) runCycles(1);
      checkOutput("rr_count", grantQ.size(), 5);
      if (grantQ.size() >= 5) begin
         checkOutput("rr_g0", 32'(grantQ[0]), 32'h1);
         checkOutput("rr_g1", 32'(grantQ[1]), 32'h2);
         checkOutput("rr_g2", 32'(grantQ[2]), 32'h4);
         checkOutput("rr_g3", 32'(grantQ[3]), 32'h8);
         checkOutput("rr_g4", 32'(grantQ[4]), 32'h1);
      end

      // Operand stability: requester 2 scrambles its operands during BUSY
      rst = 1'b1; runCycles(1); rst = 1'b0;
      holdReq = 0; req_clk_en = 4'b0100; forceLat = 12; scramble = 1;
      runCycles(18);
      scramble = 0;

      // Timeout: fpUnit never answers
      req_clk_en = 4'b1000; forceLat = 0; doneCnt = 0;
      runCycles(T + 6);
      checkOutput("tmo_done", 32'(capDone), 32'h8);
      checkOutput("tmo_result", capRes, 32'h0);
      checkOutput("tmo_count", doneCnt, 1);
      req_clk_en = 4'b0001; forceLat = 3;
      runCycles(8);
      checkOutput("tmo_sticky", 32'(timeout_err), 32'h1);

      // Reset on the 3rd BUSY cycle, then a stray fp_done
      rst = 1'b1; runCycles(1); rst = 1'b0;
      req_clk_en = 4'b0100; holdReq = 1; forceLat = 0;
      for (int c = 0; c < 10 && !(mPhase == PH_BUSY && mCnt == 2); c++) runCycles(1);
      checkOutput("rb_reached", 32'(mPhase == PH_BUSY && mCnt == 2), 32'h1);
      doneCnt = 0; grantQ.delete();
      rst = 1'b1; runCycles(1); rst = 1'b0;
      req_clk_en = 4'b1111; forceFpDone = 1;
      runCycles(1);
      forceFpDone = 0;
      runCycles(3);
      checkOutput("rb_no_done", doneCnt, 0);
      checkOutput("rb_grants", 32'(grantQ.size() >= 1), 32'h1);
      if (grantQ.size() >= 1) checkOutput("rb_next_grant", 32'(grantQ[0]), 32'h1);

      // Randomized traffic with stray fp_done, drops and operand churn
      rst = 1'b1; runCycles(1); rst = 1'b0;
      holdReq = 0; autoReq = 1; strayEn = 1; scramble = 1; forceLat = -1;
      pend = '0; dropped = '0;
      runCycles(3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
